// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
package reg_arb_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned W_DEF     = 8;
    localparam int unsigned IDX_W_DEF = $clog2(NREQ_DEF);

    typedef logic [IDX_W_DEF-1:0] owner_idx_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first valid index scanning from ptr_i upward, modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  val_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int unsigned   pos_c;
    logic [IW-1:0] pos_idx_c;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        idx_o     = '0;
        any_o     = |val_i;
        pos_c     = 0;
        pos_idx_c = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos_c     = (32'(ptr_i) + 32'(k)) % N;
            pos_idx_c = IW'(pos_c);
            if (val_i[pos_idx_c]) begin
                idx_o = pos_idx_c;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter owning a shared holding register.
// Optional hold/lock feature is enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_val,
    input  logic [NREQ*W-1:0]         req_data,
    input  logic [NREQ-1:0]           req_lock,
    output logic [NREQ-1:0]           req_rdy,
    output logic [W-1:0]              out,
    output logic [$clog2(NREQ)-1:0]   out_owner,
    output logic                      out_val,
    output logic                      upd
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win;
    logic            any;
    logic            locked;
    logic [IW-1:0]   own;
    logic [NREQ-1:0] rdy_c;
    logic            xfer;
    logic [IW-1:0]   xfer_idx;
    logic [W-1:0]    xfer_data;

    logic [W-1:0]    out_q;
    logic [IW-1:0]   owner_q;
    logic            val_q;
    logic            upd_q;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .val_i (req_val),
        .ptr_i (ptr_q),
        .idx_o (win),
        .any_o (any)
    );

    // Grant never looks at data; while locked only the owner is ready.
    always_comb begin
        rdy_c = '0;
        if (!reset) begin
            if (locked) begin
                rdy_c[own] = 1'b1;
            end else if (any) begin
                rdy_c[win] = 1'b1;
            end
        end
    end

    assign req_rdy   = rdy_c;
    assign xfer      = |(req_val & rdy_c);
    assign xfer_idx  = locked ? own : win;
    assign xfer_data = req_data[32'(xfer_idx) * W +: W];

    // Holding register and update pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            owner_q <= '0;
            val_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= xfer;
            if (xfer) begin
                out_q   <= xfer_data;
                owner_q <= xfer_idx;
                val_q   <= 1'b1;
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    arb_state_e    state_q;
    logic [IW-1:0] own_q;

    // Arbitration FSM; the pointer is frozen while a requester holds the lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (xfer) begin
                        ptr_q <= next_ptr(win);
                        if (req_lock[win]) begin
                            state_q <= LOCKED;
                            own_q   <= win;
                        end
                    end
                end
                LOCKED: begin
                    if (!req_lock[own_q]) begin
                        state_q <= ARB;
                        ptr_q   <= next_ptr(own_q);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);
    assign own    = own_q;
`else
    logic unused_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= next_ptr(win);
        end
    end

    assign locked      = 1'b0;
    assign own         = '0;
    assign unused_lock = ^req_lock;
`endif

    assign out       = out_q;
    assign out_owner = owner_q;
    assign out_val   = val_q;
    assign upd       = upd_q;

`ifdef FORMAL
    a_rdy_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_rdy));
    a_out_data: assert property (@(posedge clk) disable iff (reset)
        upd |-> (out == $past(xfer_data)));
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a rule-level model.
module tb_reg_write_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req_val;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]  req_lock;
    logic [NREQ-1:0]  req_rdy;
    logic [W-1:0]     out;
    logic [1:0]       out_owner;
    logic             out_val;
    logic             upd;

    int vectors;
    int miscompares;

    // model state
    int m_out, m_owner, m_val, m_upd, m_ptr, m_locked, m_own;
    int n_out, n_owner, n_val, n_upd, n_ptr, n_locked, n_own;

    reg_write_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_rdy   (req_rdy),
        .out       (out),
        .out_owner (out_owner),
        .out_val   (out_val),
        .upd       (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_owner = 0; m_val = 0; m_upd = 0;
        m_ptr = 0; m_locked = 0; m_own = 0;
    endtask

    function automatic logic [NREQ-1:0] exp_rdy();
        logic [NREQ-1:0] r;
        r = '0;
        if (reset) return r;
        if (m_locked != 0) begin
            r[m_own] = 1'b1;
            return r;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_val[(m_ptr + k) % NREQ]) begin
                r[(m_ptr + k) % NREQ] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_next();
        logic [NREQ-1:0] r;
        int xf, idx;
        n_out = m_out; n_owner = m_owner; n_val = m_val; n_upd = 0;
        n_ptr = m_ptr; n_locked = m_locked; n_own = m_own;
        if (reset) begin
            n_out = 0; n_owner = 0; n_val = 0; n_ptr = 0; n_locked = 0; n_own = 0;
            return;
        end
        r = exp_rdy();
        xf = 0; idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && req_val[i]) begin
                xf = 1; idx = i;
            end
        end
        n_upd = xf;
        if (xf != 0) begin
            n_out = int'(req_data[idx*W +: W]);
            n_owner = idx;
            n_val = 1;
        end
        if (m_locked == 0) begin
            if (xf != 0) begin
                n_ptr = (idx + 1) % NREQ;
`ifdef REG_ARB_LOCK_EN
                if (req_lock[idx]) begin
                    n_locked = 1; n_own = idx;
                end
`endif
            end
        end else if (!req_lock[m_own]) begin
            n_locked = 0;
            n_ptr = (m_own + 1) % NREQ;
        end
    endtask

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        @(negedge clk);
        chk("rdy",   32'(req_rdy),   32'(exp_rdy()));
        chk("out",   32'(out),       32'(m_out));
        chk("owner", 32'(out_owner), 32'(m_owner));
        chk("val",   32'(out_val),   32'(m_val));
        chk("upd",   32'(upd),       32'(m_upd));
        model_next();
        @(posedge clk);
        #1;
        m_out = n_out; m_owner = n_owner; m_val = n_val; m_upd = n_upd;
        m_ptr = n_ptr; m_locked = n_locked; m_own = n_own;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_val = '0; req_lock = '0;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        req_val = 4'hF;
        req_data = '0;
        req_lock = '0;
        model_reset();
        repeat (2) tick();

        // reset idle
        reset = 1'b0;
        req_val = '0;
        repeat (3) tick();
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_val", 32'(out_val), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_rdy", 32'(req_rdy), 32'h0);

        // single write from requester 2
        req_data = 32'h00A5_0000;
        req_val = 4'b0100;
        #1 chk("single_rdy", 32'(req_rdy), 32'b0100);
        tick();
        req_val = '0;
        chk("single_out", 32'(out), 32'hA5);
        chk("single_owner", 32'(out_owner), 32'd2);
        chk("single_upd", 32'(upd), 32'h1);

        // wrap from ptr 3
        req_data = 32'h4400_0011;
        req_val = 4'b1001;
        #1 chk("wrap_rdy3", 32'(req_rdy), 32'b1000);
        tick();
        chk("wrap_owner3", 32'(out_owner), 32'd3);
        chk("wrap_out3", 32'(out), 32'h44);
        #1 chk("wrap_rdy0", 32'(req_rdy), 32'b0001);
        tick();
        chk("wrap_owner0", 32'(out_owner), 32'd0);
        chk("wrap_out0", 32'(out), 32'h11);

        // full rotation
        do_reset();
        req_data = 32'h4030_2010;
        req_val = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rot_owner", 32'(out_owner), 32'(k % 4));
            chk("rot_out", 32'(out), 32'((k % 4 + 1) * 16));
        end
        req_val = '0;

`ifdef REG_ARB_LOCK_EN
        // lock held by requester 1 while requester 0 waits
        do_reset();
        req_data = 32'h0000_0005;
        req_val = 4'b0001;
        tick();
        req_val = 4'b0011;
        req_lock = 4'b0010;
        req_data = 32'h0000_1100;
        #1 chk("lock_rdy_a", 32'(req_rdy), 32'b0010);
        tick();
        chk("lock_out_11", 32'(out), 32'h11);
        req_data = 32'h0000_2200;
        #1 chk("lock_rdy_b", 32'(req_rdy), 32'b0010);
        tick();
        chk("lock_out_22", 32'(out), 32'h22);
        req_data = 32'h0000_3300;
        req_lock = 4'b0000;
        #1 chk("lock_rdy_c", 32'(req_rdy), 32'b0010);
        tick();
        chk("lock_out_33", 32'(out), 32'h33);
        chk("lock_owner_1", 32'(out_owner), 32'd1);
        #1 chk("unlock_rdy", 32'(req_rdy), 32'b0001);
        tick();
        chk("unlock_owner", 32'(out_owner), 32'd0);

        // reset while locked with a pending 0x77
        do_reset();
        req_val = 4'b0100;
        req_lock = 4'b0100;
        req_data = 32'h0012_0000;
        tick();
        req_data = 32'h0077_0000;
        #1 chk("mid_rdy", 32'(req_rdy), 32'b0100);
        reset = 1'b1;
        model_reset();
        tick();
        chk("mid_out", 32'(out), 32'h00);
        reset = 1'b0;
        req_lock = '0;
        req_val = 4'hF;
        #1 chk("mid_rdy_arb", 32'(req_rdy), 32'b0001);
        tick();
        chk("mid_owner", 32'(out_owner), 32'd0);
        chk("mid_out2", 32'(out), 32'h00);
        req_val = '0;
`endif

        // random traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (reset) model_reset();
            req_val  = NREQ'($urandom);
            req_data = $urandom;
            req_lock = ($urandom_range(0, 1) == 0) ? NREQ'($urandom) : '0;
            tick();
        end
        reset = 1'b0;
        req_val = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
